// File: rtl/qam_demap_pkg.sv
// Shared types, slicer thresholds and carrier constants for qam_demapper.
package qam_demap_pkg;

  localparam int unsigned FRAC_W    = 13;
  localparam int unsigned IN_W      = 16;
  localparam int unsigned AXIS_BITS = 3;
  localparam int unsigned WORD_BITS = 6;
  localparam int unsigned ACC_W     = 13;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned BYTE_W    = 8;

  typedef enum logic [1:0] {
    MOD_BPSK  = 2'd0,
    MOD_QPSK  = 2'd1,
    MOD_QAM16 = 2'd2,
    MOD_QAM64 = 2'd3
  } mod_e;

  typedef struct packed {
    logic signed [IN_W-1:0] im;
    logic signed [IN_W-1:0] re;
  } iq_t;

  // 2/sqrt(10) and 2/sqrt(42) scaled by 2^FRAC_W, truncated
  localparam int unsigned ONE_Q    = 32'd1 << FRAC_W;
  localparam int unsigned THR16_2K = (2 * ONE_Q * 31623) / 100000;
  localparam int unsigned THR64_2K = (2 * ONE_Q * 15430) / 100000;
  localparam int unsigned THR64_4K = 2 * THR64_2K;
  localparam int unsigned THR64_6K = 3 * THR64_2K;

  localparam int unsigned PILOT_IDX0 = 5;
  localparam int unsigned PILOT_IDX1 = 19;
  localparam int unsigned PILOT_IDX2 = 32;
  localparam int unsigned PILOT_IDX3 = 46;

  function automatic logic is_pilot(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(PILOT_IDX0)) || (idx == IDX_W'(PILOT_IDX1)) ||
           (idx == IDX_W'(PILOT_IDX2)) || (idx == IDX_W'(PILOT_IDX3));
  endfunction

  function automatic logic [CNT_W-1:0] bits_per_carrier(input mod_e m);
    logic [CNT_W-1:0] n;
    case (m)
      MOD_BPSK:  n = CNT_W'(1);
      MOD_QPSK:  n = CNT_W'(2);
      MOD_QAM16: n = CNT_W'(4);
      default:   n = CNT_W'(6);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/qam_slicer.sv
// Per-axis Gray hard decision: bit0 = sign, bits 1..2 from |x| against the thresholds.
module qam_slicer
  import qam_demap_pkg::*;
(
  input  logic signed [IN_W-1:0]      x_i,
  input  mod_e                        mod_i,
  output logic        [AXIS_BITS-1:0] bits_c
);

  logic signed [IN_W:0] x_ext;
  logic        [IN_W:0] x_abs;

  always_comb begin
    x_ext  = {x_i[IN_W-1], x_i};
    // one extra bit so that -32768 has a representable magnitude
    x_abs  = x_ext[IN_W] ? -x_ext : x_ext;
    bits_c = '0;
    bits_c[0] = ~x_i[IN_W-1];
    case (mod_i)
      MOD_QAM16: bits_c[1] = x_abs < (IN_W+1)'(THR16_2K);
      MOD_QAM64: begin
        bits_c[1] = x_abs < (IN_W+1)'(THR64_4K);
        bits_c[2] = (x_abs >= (IN_W+1)'(THR64_2K)) && (x_abs < (IN_W+1)'(THR64_6K));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/qam_demapper.sv
// 802.11a/g hard-decision demapper: input register, slicer, LSB-first byte packer, master port.
// QAM_DEMAP_PILOT_DROP_EN: 52 carriers per symbol with pilots dropped; otherwise 48 data carriers.
module qam_demapper
  import qam_demap_pkg::*;
(
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [31:0] DAT_I,
  input  logic        WE_I,
  input  logic        STB_I,
  input  logic        CYC_I,
  output logic        ACK_O,
  input  logic [1:0]  MOD_I,
  output logic [7:0]  DAT_O,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  input  logic        ACK_I
);

`ifdef QAM_DEMAP_PILOT_DROP_EN
  localparam int unsigned IDX_LAST = 51;
`else
  localparam int unsigned IDX_LAST = 47;
`endif

  logic              cyc_in_q, cyc_in_d;
  mod_e              mod_q, mod_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  iq_t               in_q, in_d;
  logic              ival_q, ival_d;
  logic              pil_q, pil_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] dat_q, dat_d;
  logic              stb_q, stb_d;
  logic              cyc_out_q, cyc_out_d;

  logic                 out_halt;
  logic                 cyc_rise;
  logic [IDX_W-1:0]     idx_cur;
  mod_e                 mod_cur;
  logic                 cur_pilot;
  logic [AXIS_BITS-1:0] re_bits, im_bits;
  logic [WORD_BITS-1:0] word_bits;
  logic [CNT_W-1:0]     nbits;
  logic                 emit;
  logic                 take;
  logic                 drained;
  logic [ACC_W-1:0]     acc_base;
  logic [CNT_W-1:0]     cnt_base;

  assign out_halt = stb_q & ~ACK_I;
  assign ACK_O    = WE_I & STB_I & CYC_I & ~out_halt;
  assign DAT_O    = dat_q;
  assign STB_O    = stb_q;
  assign CYC_O    = cyc_out_q;
  assign WE_O     = cyc_out_q;

  // a burst start restarts the carrier index and latches the modulation
  assign cyc_rise = CYC_I & ~cyc_in_q;
  assign idx_cur  = cyc_rise ? '0 : idx_q;
  assign mod_cur  = cyc_rise ? mod_e'(MOD_I) : mod_q;

`ifdef QAM_DEMAP_PILOT_DROP_EN
  assign cur_pilot = is_pilot(idx_cur);
`else
  assign cur_pilot = 1'b0;
`endif

  qam_slicer u_slice_re (
    .x_i    (in_q.re),
    .mod_i  (mod_q),
    .bits_c (re_bits)
  );

  qam_slicer u_slice_im (
    .x_i    (in_q.im),
    .mod_i  (mod_q),
    .bits_c (im_bits)
  );

  // Re decisions occupy the low bits, Im decisions follow
  always_comb begin
    word_bits = '0;
    case (mod_q)
      MOD_BPSK:  word_bits = WORD_BITS'(re_bits[0]);
      MOD_QPSK:  word_bits = WORD_BITS'({im_bits[0], re_bits[0]});
      MOD_QAM16: word_bits = WORD_BITS'({im_bits[1:0], re_bits[1:0]});
      default:   word_bits = {im_bits, re_bits};
    endcase
  end

  assign nbits    = bits_per_carrier(mod_q);
  assign emit     = cnt_q >= CNT_W'(BYTE_W);
  assign take     = ival_q & ~pil_q;
  assign drained  = ~CYC_I & ~ival_q & ~emit;
  assign acc_base = emit ? (acc_q >> BYTE_W) : acc_q;
  assign cnt_base = emit ? (cnt_q - CNT_W'(BYTE_W)) : cnt_q;

  always_comb begin
    cyc_in_d  = cyc_in_q;
    mod_d     = mod_q;
    idx_d     = idx_q;
    in_d      = in_q;
    ival_d    = ival_q;
    pil_d     = pil_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    dat_d     = dat_q;
    stb_d     = stb_q;
    cyc_out_d = cyc_out_q;
    if (!out_halt) begin
      cyc_in_d = CYC_I;
      mod_d    = mod_cur;
      idx_d    = idx_cur;
      ival_d   = ACK_O;
      if (ACK_O) begin
        in_d  = iq_t'(DAT_I);
        pil_d = cur_pilot;
        idx_d = (idx_cur == IDX_W'(IDX_LAST)) ? '0 : idx_cur + IDX_W'(1);
      end
      stb_d = emit;
      if (emit) begin
        dat_d = acc_q[BYTE_W-1:0];
      end
      // leftover bits of a truncated burst are dropped once the pipe is empty
      if (take) begin
        acc_d = acc_base | (ACC_W'(word_bits) << cnt_base);
        cnt_d = cnt_base + nbits;
      end else if (drained) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = acc_base;
        cnt_d = cnt_base;
      end
      cyc_out_d = emit | (cyc_out_q & (CYC_I | ival_q));
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      cyc_in_q  <= 1'b0;
      mod_q     <= MOD_BPSK;
      idx_q     <= '0;
      in_q      <= '0;
      ival_q    <= 1'b0;
      pil_q     <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      dat_q     <= '0;
      stb_q     <= 1'b0;
      cyc_out_q <= 1'b0;
    end else begin
      cyc_in_q  <= cyc_in_d;
      mod_q     <= mod_d;
      idx_q     <= idx_d;
      in_q      <= in_d;
      ival_q    <= ival_d;
      pil_q     <= pil_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      dat_q     <= dat_d;
      stb_q     <= stb_d;
      cyc_out_q <= cyc_out_d;
    end
  end

endmodule

// File: tb/tb_qam_demapper.sv
// Randomized bench for qam_demapper against a bit-queue reference model.
module tb_qam_demapper;

`ifdef QAM_DEMAP_PILOT_DROP_EN
  localparam int WPS = 52;
  int pilot_set[$] = '{5, 19, 32, 46};
`else
  localparam int WPS = 48;
  int pilot_set[$];
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] dat_i;
  logic        we_i, stb_i, cyc_i;
  logic        ack_o;
  logic [1:0]  mod_i;
  logic [7:0]  dat_o;
  logic        cyc_o, stb_o, we_o;
  logic        ack_i;

  qam_demapper dut (
    .CLK_I (clk),
    .RST_I (rst_n),
    .DAT_I (dat_i),
    .WE_I  (we_i),
    .STB_I (stb_i),
    .CYC_I (cyc_i),
    .ACK_O (ack_o),
    .MOD_I (mod_i),
    .DAT_O (dat_o),
    .CYC_O (cyc_o),
    .STB_O (stb_o),
    .WE_O  (we_o),
    .ACK_I (ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] data_q[$];
  bit          exp_bits[$];
  logic [7:0]  exp_bytes[$];
  logic [7:0]  got_bytes[$];
  logic [31:0] pilot_w;
  logic        ack_force = 1'b1;
  logic        ack_rand  = 1'b0;
  int          edges[15] = '{0, 1, 1264, 2527, 2528, 5055, 5056, 5180, 5181,
                             5182, 5793, 7583, 7584, 32767, 32768};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mkw(input int re, input int im);
    return {16'(im), 16'(re)};
  endfunction

  function automatic logic [15:0] rnd_comp();
    int e;
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    e = edges[$urandom_range(0, 14)];
    if ($urandom_range(0, 1) == 1) e = -e;
    return 16'(e);
  endfunction

  function automatic bit tb_pilot(input int i);
    foreach (pilot_set[j]) if (pilot_set[j] == i) return 1'b1;
    return 1'b0;
  endfunction

  // reference decisions straight from the constellation thresholds
  task automatic axis16(input int x);
    int a;
    a = (x < 0) ? -x : x;
    exp_bits.push_back(x >= 0);
    exp_bits.push_back(a < 5181);
  endtask

  task automatic axis64(input int x);
    int a;
    a = (x < 0) ? -x : x;
    exp_bits.push_back(x >= 0);
    exp_bits.push_back(a < 5056);
    exp_bits.push_back(a >= 2528 && a < 7584);
  endtask

  task automatic model_word(input logic [1:0] mod, input logic [31:0] w);
    logic signed [15:0] r16, i16;
    int re, im;
    r16 = w[15:0];
    i16 = w[31:16];
    re  = r16;
    im  = i16;
    case (mod)
      2'd0: exp_bits.push_back(re >= 0);
      2'd1: begin exp_bits.push_back(re >= 0); exp_bits.push_back(im >= 0); end
      2'd2: begin axis16(re); axis16(im); end
      default: begin axis64(re); axis64(im); end
    endcase
  endtask

  task automatic pack_model();
    logic [7:0] b;
    while (exp_bits.size() >= 8) begin
      for (int i = 0; i < 8; i++) b[i] = exp_bits.pop_front();
      exp_bytes.push_back(b);
    end
    exp_bits.delete();
  endtask

  task automatic send_word(input logic [31:0] w);
    int guard;
    guard = 0;
    dat_i = w;
    we_i  = 1'b1;
    stb_i = 1'b1;
    @(negedge clk);
    while (ack_o !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) chk("ack_o_timeout", 32'(ack_o), 1);
    @(posedge clk);
    #1;
    stb_i = 1'b0;
    we_i  = 1'b0;
  endtask

  task automatic run_burst(input string tag, input logic [1:0] mod);
    int pos, idx, guard;
    got_bytes.delete();
    exp_bytes.delete();
    exp_bits.delete();
    foreach (data_q[i]) model_word(mod, data_q[i]);
    pack_model();
    mod_i = mod;
    cyc_i = 1'b1;
    pos = 0;
    idx = 0;
    while (pos < data_q.size()) begin
      if (tb_pilot(idx)) send_word(pilot_w);
      else begin
        send_word(data_q[pos]);
        pos++;
        mod_i = 2'($urandom_range(0, 3));
      end
      idx = (idx == WPS - 1) ? 0 : idx + 1;
    end
    cyc_i = 1'b0;
    repeat (3) @(negedge clk);
    guard = 0;
    while (cyc_o === 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "/cyc_o_low"}, 32'(cyc_o), 0);
    chk({tag, "/n_bytes"}, got_bytes.size(), exp_bytes.size());
    for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
      chk($sformatf("%s/byte%0d", tag, i), got_bytes[i], exp_bytes[i]);
    @(posedge clk);
    #1;
  endtask

  // single driver of ACK_I: forced level or random back-pressure
  always begin
    @(posedge clk);
    #1;
    ack_i = ack_rand ? ($urandom_range(0, 3) != 0) : ack_force;
  end

  // byte capture plus hold/halt behaviour of the master port
  logic       prev_hold = 1'b0;
  logic [7:0] prev_dat  = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hold) begin
        chk("stb_hold", 32'(stb_o), 1);
        chk("dat_hold", dat_o, prev_dat);
      end
      if (stb_o && !ack_i && stb_i && cyc_i && we_i) chk("ack_o_halt", 32'(ack_o), 0);
      if (stb_o && ack_i) got_bytes.push_back(dat_o);
    end
    prev_hold = rst_n && stb_o && !ack_i;
    prev_dat  = dat_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ack_i = 1'b1;
    rst_n = 1'b0;
    dat_i = '0;
    we_i  = 1'b0;
    stb_i = 1'b0;
    cyc_i = 1'b0;
    mod_i = 2'd0;
    pilot_w = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/stb_o", 32'(stb_o), 0);
    chk("rst/cyc_o", 32'(cyc_o), 0);
    chk("rst/we_o",  32'(we_o), 0);
    chk("rst/dat_o", dat_o, 0);
    chk("rst/ack_o", 32'(ack_o), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    data_q.delete();
    for (int i = 0; i < 48; i++) data_q.push_back((i % 2 == 0) ? mkw(5793, 5793) : mkw(-5793, 5793));
    pilot_w = $urandom;
    run_burst("qpsk", 2'd1);
    if (got_bytes.size() > 0) chk("qpsk/0xBB", got_bytes[0], 8'hBB);

    data_q.delete();
    for (int i = 0; i < 48; i++) data_q.push_back(mkw(8848, -1264));
    pilot_w = 32'h7FFF7FFF;
    run_burst("qam64", 2'd3);
    if (got_bytes.size() > 2) begin
      chk("qam64/b0", got_bytes[0], 8'h51);
      chk("qam64/b1", got_bytes[1], 8'h14);
      chk("qam64/b2", got_bytes[2], 8'h45);
    end

    data_q.delete();
    for (int i = 0; i < 48; i++) data_q.push_back(mkw((i % 2 == 0) ? 0 : -1, int'(rnd_comp())));
    pilot_w = $urandom;
    run_burst("bpsk", 2'd0);
    if (got_bytes.size() > 0) chk("bpsk/0x55", got_bytes[0], 8'h55);

    data_q.delete();
    for (int i = 0; i < 48; i++) data_q.push_back({rnd_comp(), rnd_comp()});
    fork
      run_burst("qam16_stall", 2'd2);
      begin
        repeat (20) @(posedge clk);
        #1;
        ack_force = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        ack_force = 1'b1;
      end
    join

    data_q.delete();
    for (int i = 0; i < 10; i++) data_q.push_back((i % 2 == 0) ? mkw(5793, 5793) : mkw(-5793, 5793));
    run_burst("qpsk_short", 2'd1);
    data_q.delete();
    for (int i = 0; i < 48; i++) data_q.push_back({rnd_comp(), rnd_comp()});
    run_burst("qpsk_after", 2'd1);

    mod_i = 2'd3;
    cyc_i = 1'b1;
    for (int i = 0; i < 20; i++) send_word(mkw(8848, -1264));
    rst_n = 1'b0;
    cyc_i = 1'b0;
    #1;
    chk("midrst/stb_o", 32'(stb_o), 0);
    chk("midrst/cyc_o", 32'(cyc_o), 0);
    chk("midrst/dat_o", dat_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    data_q.delete();
    for (int i = 0; i < 48; i++) data_q.push_back(mkw(8848, -1264));
    pilot_w = 32'h7FFF7FFF;
    run_burst("qam64_rst", 2'd3);
    if (got_bytes.size() > 2) begin
      chk("qam64_rst/b0", got_bytes[0], 8'h51);
      chk("qam64_rst/b1", got_bytes[1], 8'h14);
      chk("qam64_rst/b2", got_bytes[2], 8'h45);
    end

    ack_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      int nsym;
      logic [1:0] m;
      nsym = int'($urandom_range(1, 2));
      m    = 2'($urandom_range(0, 3));
      data_q.delete();
      for (int i = 0; i < 48 * nsym; i++) data_q.push_back({rnd_comp(), rnd_comp()});
      pilot_w = $urandom;
      run_burst($sformatf("rnd%0d", r), m);
    end
    ack_rand = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
